controle_jogo: RTL
==================

Name: controle_jogo

Overview:
- Game-round controller for the guess-the-password datapath.
- Latches the secret and each guess, and drives the difference/sign pair into the difference comparator (igual / ate3 outputs).
- Samples the comparator verdict, counts down remaining attempts and declares win or loss.
- Sits between the board buttons/switches and the comparator; feeds the display/LED logic.

Parameters:
- MAX_TENT, 5: attempts per round (1..2^CNT_W-1).
- CNT_W, 3: width of the attempt counter.
- TIMEOUT_CICLOS, 50000000: guess time limit in clock cycles. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- iniciar  in  1  start/restart round (raw level; rising edge detected internally)
- confirmar  in  1  submit guess (raw level; rising edge detected internally)
- senha  in  4  secret, unsigned 0..15, latched on start
- tentativa  in  4  guess, unsigned 0..15, latched on confirm
- cmp_igual  in  1  comparator "equal" result
- cmp_ate3  in  1  comparator "within 3, not equal" result
- cmp_diff  out  4  low 4 bits of (guess - secret), to comparator
- cmp_sinal  out  1  sign of (guess - secret), 1 = negative
- res_acertou  out  1  last attempt equal
- res_perto  out  1  last attempt within 3
- res_longe  out  1  last attempt farther than 3
- restantes  out  CNT_W  attempts left
- vitoria  out  1  round won (held)
- derrota  out  1  round lost (held)
- ocupado  out  1  comparison in progress
- estado  out  3  current FSM state code

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: all outputs 0; FSM in OCIOSO; edge-detector history registers 0.
- Edge detection: one register per button. The pulse is high for one cycle after a 0->1 transition. A held button gives a single pulse.
- Arithmetic: d = {1'b0,guess_q} - {1'b0,senha_q}, 5-bit two's complement.
  - cmp_diff = d[3:0], cmp_sinal = d[4].
  - Both are registered outputs, updated on the guess-latch edge.
- States (estado code):
  - OCIOSO (0): outputs idle, restantes = 0. An iniciar pulse latches senha, loads restantes = MAX_TENT, clears res_*/vitoria/derrota, and moves to ESPERA.
  - ESPERA (1): a confirmar pulse latches tentativa and moves to COMPARA.
  - COMPARA (2): ocupado = 1. One settle cycle for the combinational comparator. Moves to AVALIA unconditionally.
  - AVALIA (3): ocupado = 1. On exit, samples cmp_igual/cmp_ate3 into exactly one of res_acertou / res_perto / res_longe (one-hot, held until the next evaluation or start) and decrements restantes. Next state:
    - cmp_igual -> VITORIA;
    - otherwise restantes was 1 -> DERROTA;
    - otherwise -> ESPERA.
  - VITORIA (4): vitoria = 1. Held until an iniciar pulse or rst.
  - DERROTA (5): derrota = 1. Held until an iniciar pulse or rst.
- Latency: res_* and restantes update 2 clocks after the guess-latch edge. vitoria/derrota assert on the same edge as res_*.
- Start pulse in any state: restarts the round exactly as from OCIOSO, including mid-comparison.
- Start and confirm pulses in the same cycle: start wins; the guess is discarded.
- Confirm pulses in COMPARA, AVALIA, VITORIA, DERROTA or OCIOSO: ignored, not queued.
- Last attempt correct: vitoria only; derrota never asserts.
- restantes never wraps below 0.
- rst mid-round: immediate return to reset values; no partial results remain.

Optional Feature:
- Macro: CONTROLE_JOGO_TIMEOUT_EN.
- Defined: a cycle counter runs in ESPERA and clears on entry to ESPERA. Reaching TIMEOUT_CICLOS-1 without a confirm pulse consumes one attempt:
  - res_longe = 1, restantes decremented;
  - -> DERROTA if restantes was 1, else ESPERA with the counter cleared.
  - A confirm pulse in the same cycle as expiry wins.
- Not defined: no counter logic; ESPERA waits indefinitely.

Decomposition:
- Shared include file holds:
  - state codes OCIOSO..DERROTA (3-bit localparams);
  - result one-hot constants;
  - default MAX_TENT.
- Sub-module detector_borda (1-bit rising-edge pulse, async reset). Instantiated twice: iniciar and confirmar.
- The comparator is instantiated beside this block at the top level, not inside it.

Test Plan:
- Reset mid-COMPARA: all outputs 0, estado = 0. The next iniciar pulse gives restantes = 5.
- Exact hit: senha = 9, tentativa = 9. Expect cmp_diff = 0, cmp_sinal = 0, then res_acertou = 1, vitoria = 1, restantes = 4, 2 clocks after latch.
- Near and far: senha = 7, guesses 5 then 12.
  - Guess 5: cmp_diff = 4'b1110, cmp_sinal = 1, res_perto = 1.
  - Guess 12: cmp_diff = 5, cmp_sinal = 0, res_longe = 1, restantes = 3.
- Loss: five wrong guesses (senha = 0, tentativa = 15 each). Expect derrota = 1, restantes = 0. A sixth confirm is ignored.
- Button held 20 cycles in ESPERA: exactly one evaluation; restantes drops by 1 only.
- Simultaneous iniciar + confirmar in ESPERA: round restarts, no evaluation, restantes = MAX_TENT.
- With CONTROLE_JOGO_TIMEOUT_EN and TIMEOUT_CICLOS = 10: no confirm for 10 cycles -> res_longe = 1, restantes decremented by 1.

Source files
------------

// File: rtl/controle_jogo_pkg.sv
// ----------------------------------------------------------------------------
// controle_jogo_pkg
//   Shared definitions for the guess-the-password round controller:
//   - FSM state codes (3-bit, also exported on the estado port)
//   - one-hot result codes for the res_acertou/res_perto/res_longe trio
//   - default number of attempts per round
//   - signed 5-bit difference helper used to feed the comparator
//   Optional feature macro used by the controller: CONTROLE_JOGO_TIMEOUT_EN
// ----------------------------------------------------------------------------
package controle_jogo_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    ESPERA  = 3'd1,
    COMPARA = 3'd2,
    AVALIA  = 3'd3,
    VITORIA = 3'd4,
    DERROTA = 3'd5
  } estado_t;

  // Result one-hot: bit0 = acertou, bit1 = perto, bit2 = longe
  localparam logic [2:0] RES_NENHUM  = 3'b000;
  localparam logic [2:0] RES_ACERTOU = 3'b001;
  localparam logic [2:0] RES_PERTO   = 3'b010;
  localparam logic [2:0] RES_LONGE   = 3'b100;

  localparam int MAX_TENT_PADRAO = 5;

  // guess - secret as 5-bit two's complement; both operands are unsigned 0..15
  function automatic logic signed [4:0] diferenca(input logic [3:0] palpite,
                                                  input logic [3:0] segredo);
    logic signed [4:0] a;
    logic signed [4:0] b;
    a = $signed({1'b0, palpite});
    b = $signed({1'b0, segredo});
    return a - b;
  endfunction

endpackage

// File: rtl/controle_jogo_detector_borda.sv
// ----------------------------------------------------------------------------
// detector_borda
//   1-bit rising-edge detector. pulso is high for exactly one cycle after the
//   raw input goes 0->1; holding the input high produces a single pulse.
//   Ports:
//     clk    in  clock
//     rst    in  asynchronous active-high reset (history cleared to 0)
//     sinal  in  raw button level
//     pulso  out single-cycle rising-edge pulse
// ----------------------------------------------------------------------------
module detector_borda (
  input  logic clk,
  input  logic rst,
  input  logic sinal,
  output logic pulso
);

  logic hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= sinal;
    end
  end

  assign pulso = sinal & ~hist_q;

endmodule

// File: rtl/controle_jogo.sv
// ----------------------------------------------------------------------------
// controle_jogo
//   Round controller for the guess-the-password game. Latches the secret on
//   start, latches each guess as a (difference, sign) pair for the external
//   difference comparator, samples the comparator verdict, counts attempts
//   down and declares win or loss.
//
//   Optional feature (macro CONTROLE_JOGO_TIMEOUT_EN): a guess timer that
//   consumes one attempt (as a "far" result) when no guess is submitted within
//   TIMEOUT_CICLOS cycles in ESPERA. Without the macro ESPERA waits forever.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     iniciar, confirmar       raw button levels (edges detected here)
//     senha, tentativa         secret / guess, unsigned 0..15
//     cmp_igual, cmp_ate3      comparator verdict
//     cmp_diff, cmp_sinal      low 4 bits and sign of (guess - secret)
//     res_acertou/perto/longe  one-hot result of the last evaluation
//     restantes                attempts left
//     vitoria, derrota         round outcome (held)
//     ocupado                  comparison in progress
//     estado                   current FSM state code
// ----------------------------------------------------------------------------
module controle_jogo
  import controle_jogo_pkg::*;
#(
  parameter int MAX_TENT       = MAX_TENT_PADRAO,
  parameter int CNT_W          = 3,
  parameter int TIMEOUT_CICLOS = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iniciar,
  input  logic             confirmar,
  input  logic [3:0]       senha,
  input  logic [3:0]       tentativa,
  input  logic             cmp_igual,
  input  logic             cmp_ate3,
  output logic [3:0]       cmp_diff,
  output logic             cmp_sinal,
  output logic             res_acertou,
  output logic             res_perto,
  output logic             res_longe,
  output logic [CNT_W-1:0] restantes,
  output logic             vitoria,
  output logic             derrota,
  output logic             ocupado,
  output logic [2:0]       estado
);

  localparam logic [CNT_W-1:0] TENT_INI = CNT_W'(MAX_TENT);

  if (MAX_TENT < 1 || MAX_TENT >= (1 << CNT_W) || TIMEOUT_CICLOS < 2) begin : g_param_invalido
    $error("controle_jogo: MAX_TENT must be 1..2^CNT_W-1 and TIMEOUT_CICLOS >= 2");
  end

  // Attempt counter never wraps below zero
  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  logic pulso_ini;
  logic pulso_conf;

  detector_borda u_borda_iniciar (
    .clk   (clk),
    .rst   (rst),
    .sinal (iniciar),
    .pulso (pulso_ini)
  );

  detector_borda u_borda_confirmar (
    .clk   (clk),
    .rst   (rst),
    .sinal (confirmar),
    .pulso (pulso_conf)
  );

  estado_t           estado_q;
  logic [3:0]        senha_q;
  logic signed [4:0] dif_q;
  logic [2:0]        res_q;
  logic [CNT_W-1:0]  restantes_q;
  logic              vitoria_q;
  logic              derrota_q;
  logic              ocupado_q;

`ifdef CONTROLE_JOGO_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TMR_W-1:0] TMR_FIM = TMR_W'(TIMEOUT_CICLOS - 1);
  logic [TMR_W-1:0] timer_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q    <= OCIOSO;
      senha_q     <= '0;
      dif_q       <= '0;
      res_q       <= RES_NENHUM;
      restantes_q <= '0;
      vitoria_q   <= 1'b0;
      derrota_q   <= 1'b0;
      ocupado_q   <= 1'b0;
`ifdef CONTROLE_JOGO_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else if (pulso_ini) begin
      // Start has priority over everything, including a simultaneous confirm
      // and a comparison in flight.
      estado_q    <= ESPERA;
      senha_q     <= senha;
      res_q       <= RES_NENHUM;
      restantes_q <= TENT_INI;
      vitoria_q   <= 1'b0;
      derrota_q   <= 1'b0;
      ocupado_q   <= 1'b0;
`ifdef CONTROLE_JOGO_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
      case (estado_q)
        OCIOSO: begin
          estado_q <= OCIOSO;
        end

        ESPERA: begin
          if (pulso_conf) begin
            // The registered difference is the latched guess as seen by the
            // comparator.
            dif_q     <= diferenca(tentativa, senha_q);
            ocupado_q <= 1'b1;
            estado_q  <= COMPARA;
`ifdef CONTROLE_JOGO_TIMEOUT_EN
          end else if (timer_q == TMR_FIM) begin
            res_q       <= RES_LONGE;
            restantes_q <= dec_sat(restantes_q);
            timer_q     <= '0;
            if (restantes_q <= 1) begin
              derrota_q <= 1'b1;
              estado_q  <= DERROTA;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
`endif
          end
        end

        COMPARA: begin
          // Settle cycle for the combinational comparator
          estado_q <= AVALIA;
        end

        AVALIA: begin
          ocupado_q   <= 1'b0;
          restantes_q <= dec_sat(restantes_q);
          if (cmp_igual) begin
            res_q     <= RES_ACERTOU;
            vitoria_q <= 1'b1;
            estado_q  <= VITORIA;
          end else begin
            res_q <= cmp_ate3 ? RES_PERTO : RES_LONGE;
            if (restantes_q <= 1) begin
              derrota_q <= 1'b1;
              estado_q  <= DERROTA;
            end else begin
              estado_q <= ESPERA;
`ifdef CONTROLE_JOGO_TIMEOUT_EN
              timer_q  <= '0;
`endif
            end
          end
        end

        VITORIA: estado_q <= VITORIA;
        DERROTA: estado_q <= DERROTA;

        default: begin
          estado_q  <= OCIOSO;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmp_diff    = dif_q[3:0];
  assign cmp_sinal   = dif_q[4];
  assign res_acertou = res_q[0];
  assign res_perto   = res_q[1];
  assign res_longe   = res_q[2];
  assign restantes   = restantes_q;
  assign vitoria     = vitoria_q;
  assign derrota     = derrota_q;
  assign ocupado     = ocupado_q;
  assign estado      = estado_q;

endmodule
